// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling on an oversample tick, optional parity,
// 1 or 2 stop bits, start-glitch rejection and break recovery.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rxs;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 w_ferr_next;

    assign w_ferr_next = r_ferr | ~r_rxs;
    assign busy        = (r_state != IDLE);

    // Idle-high synchroniser so reset never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (tick) begin
                case (r_state)
                    IDLE: begin
                        if (!r_rxs) begin
                            r_cnt   <= '0;
                            r_state <= START;
                        end
                    end
                    START: begin
                        if (r_cnt == CNT_MID) begin
                            if (r_rxs) begin
                                r_state <= IDLE;
                            end else begin
                                r_cnt      <= '0;
                                r_bit_idx  <= '0;
                                r_stop_idx <= 1'b0;
                                r_perr     <= 1'b0;
                                r_ferr     <= 1'b0;
                                r_state    <= DATA;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (r_cnt == CNT_END) begin
                            r_cnt     <= '0;
                            // LSB arrives first, so shifting right leaves it at bit 0
                            r_shift   <= {r_rxs, r_shift[DATA_BITS-1:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                            if (r_bit_idx == BIT_LAST)
                                r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (r_cnt == CNT_END) begin
                            r_cnt   <= '0;
                            r_perr  <= (((^r_shift) ^ r_rxs) != ODD);
                            r_state <= STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (r_cnt == CNT_END) begin
                            r_cnt <= '0;
                            if (r_stop_idx == STOP_LAST) begin
                                data       <= r_shift;
                                parity_err <= r_perr;
                                frame_err  <= w_ferr_next;
                                data_valid <= 1'b1;
                                r_state    <= w_ferr_next ? BRK_WAIT : IDLE;
                            end else begin
                                r_stop_idx <= 1'b1;
                                r_ferr     <= w_ferr_next;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    BRK_WAIT: begin
                        if (r_rxs)
                            r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) on a shared
// clock, tick and reset, each with its own serial line.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [2:0] rxl;

    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       dv0, dv1, dv2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       bz0, bz1, bz2;

    int checks   = 0;
    int failures = 0;
    int tcount   = 0;
    int nv0 = 0, nv1 = 0, nv2 = 0;
    int vtick0 = 0;
    int consec = 0;
    logic pdv0 = 1'b0, pdv1 = 1'b0, pdv2 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param u8n1 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rxl[0]),
        .data(d0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0), .busy(bz0)
    );

    uart_rx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u8e1 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rxl[1]),
        .data(d1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1), .busy(bz1)
    );

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u7n2 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rxl[2]),
        .data(d2), .data_valid(dv2), .parity_err(pe2), .frame_err(fe2), .busy(bz2)
    );

    // Pulse bookkeeping sampled mid-cycle
    always @(negedge clk) begin
        if (dv0) begin
            nv0    <= nv0 + 1;
            vtick0 <= tcount;
        end
        if (dv1) nv1 <= nv1 + 1;
        if (dv2) nv2 <= nv2 + 1;
        if ((dv0 && pdv0) || (dv1 && pdv1) || (dv2 && pdv2)) consec <= consec + 1;
        pdv0 <= dv0;
        pdv1 <= dv1;
        pdv2 <= dv2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("assertion on %s", tag);
        end
    endtask

    // Each tick: one clk with tick high, one with it low; everything changes on negedge
    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            tcount++;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic drive(input int s, input logic b);
        rxl    = 3'b111;
        rxl[s] = b;
    endtask

    task automatic send(input int s, input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            drive(s, f[i]);
            tk(16);
        end
        drive(s, 1'b1);
        tk(32);
    endtask

    int base, tstart;

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        rxl   = 3'b111;
        repeat (3) @(negedge clk);
        tk(2);
        chk("rst_data", {24'd0, d0}, 32'h0);
        chk("rst_valid", {31'd0, dv0}, 32'h0);
        chk("rst_perr", {31'd0, pe0}, 32'h0);
        chk("rst_ferr", {31'd0, fe0}, 32'h0);
        chk("rst_busy", {29'd0, bz2, bz1, bz0}, 32'h0);
        reset = 1'b0;
        tk(4);

        // 8N1 0xA5, with latency from the first low tick
        base   = nv0;
        tstart = tcount;
        send(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
        chk("a5_count", nv0 - base, 1);
        chk("a5_data", {24'd0, d0}, 32'hA5);
        chk("a5_perr", {31'd0, pe0}, 32'h0);
        chk("a5_ferr", {31'd0, fe0}, 32'h0);
        chk("a5_busy", {31'd0, bz0}, 32'h0);
        chk("a5_latency", vtick0 - tstart, 154);

        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        base = nv1;
        send(1, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        chk("par_ok_count", nv1 - base, 1);
        chk("par_ok_data", {24'd0, d1}, 32'h07);
        chk("par_ok_perr", {31'd0, pe1}, 32'h0);
        send(1, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        chk("par_bad_count", nv1 - base, 2);
        chk("par_bad_data", {24'd0, d1}, 32'h07);
        chk("par_bad_perr", {31'd0, pe1}, 32'h1);
        chk("par_bad_ferr", {31'd0, fe1}, 32'h0);

        // Start-bit glitch of 4 ticks
        base = nv0;
        drive(0, 1'b0);
        tk(4);
        drive(0, 1'b1);
        tk(5);
        chk("glitch_busy_hi", {31'd0, bz0}, 32'h1);
        tk(1);
        chk("glitch_busy_lo", {31'd0, bz0}, 32'h0);
        tk(16);
        chk("glitch_count", nv0 - base, 0);
        send(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10);
        chk("3c_count", nv0 - base, 1);
        chk("3c_data", {24'd0, d0}, 32'h3C);

        // Break: line low for 30 bit times
        base = nv0;
        drive(0, 1'b0);
        tk(16 * 30);
        chk("brk_count", nv0 - base, 1);
        chk("brk_data", {24'd0, d0}, 32'h00);
        chk("brk_ferr", {31'd0, fe0}, 32'h1);
        chk("brk_busy", {31'd0, bz0}, 32'h1);
        drive(0, 1'b1);
        tk(32);
        chk("brk_idle", {31'd0, bz0}, 32'h0);
        chk("brk_flag_hold", {31'd0, fe0}, 32'h1);
        send(0, {6'd0, 1'b1, 8'h55, 1'b0}, 10);
        chk("55_count", nv0 - base, 2);
        chk("55_data", {24'd0, d0}, 32'h55);
        chk("55_ferr", {31'd0, fe0}, 32'h0);

        // 7 data bits, 2 stop bits
        base = nv2;
        send(2, {6'd0, 1'b0, 1'b1, 7'h41, 1'b0}, 10);
        chk("s2_bad_count", nv2 - base, 1);
        chk("s2_bad_ferr", {31'd0, fe2}, 32'h1);
        chk("s2_bad_data", {25'd0, d2}, 32'h41);
        send(2, {6'd0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
        chk("s2_ok_count", nv2 - base, 2);
        chk("s2_ok_ferr", {31'd0, fe2}, 32'h0);
        chk("s2_ok_data", {25'd0, d2}, 32'h41);
        chk("s2_busy", {31'd0, bz2}, 32'h0);

        // Reset in the middle of data bit 4 of 0x81
        base = nv0;
        for (int i = 0; i < 5; i++) begin
            drive(0, (i == 0) ? 1'b0 : ((8'h81 >> (i - 1)) & 8'h1) != 0);
            tk(16);
        end
        drive(0, 1'b0);
        tk(8);
        chk("mid_busy_pre", {31'd0, bz0}, 32'h1);
        reset = 1'b1;
        tk(2);
        chk("mid_rst_data", {24'd0, d0}, 32'h0);
        chk("mid_rst_ferr", {31'd0, fe0}, 32'h0);
        chk("mid_rst_busy", {31'd0, bz0}, 32'h0);
        chk("mid_rst_valid", {31'd0, dv0}, 32'h0);
        drive(0, 1'b1);
        reset = 1'b0;
        tk(32);
        chk("mid_count", nv0 - base, 0);
        send(0, {6'd0, 1'b1, 8'h81, 1'b0}, 10);
        chk("81_count", nv0 - base, 1);
        chk("81_data", {24'd0, d0}, 32'h81);
        chk("81_ferr", {31'd0, fe0}, 32'h0);

        chk("valid_consecutive", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
